id_stage: RTL and testbench
===========================

# id_stage

Decode stage of the five-stage MIPS32 integer pipeline, including the ID/EX pipeline register. It accepts one instruction word per cycle from fetch and reads operands from the register file. It resolves operand hazards against the EX and MEM writeback buses, then presents a registered operation (`aluop`, `alusel`, operands, destination) to the execute stage on the next cycle. Scope covers the logic, shift and logic-immediate subset of MIPS32.

## Interface
Parameters:
- none; widths fixed: instruction 32, register 32, register address 5, aluop 8, alusel 3.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `inst_valid_i` in 1: `inst_i` holds a valid instruction.
- `inst_i` in 32: instruction word.
- `inst_ready_o` out 1: instruction accepted this cycle when both valid and ready are high.
- `flush_i` in 1: discard the pending EX-bound operation.
- `stall_i` in 1: downstream stall; hold the ID/EX register.
- `re1_o`, `re2_o` out 1: register-file read enables.
- `raddr1_o`, `raddr2_o` out 5: read addresses.
- `rdata1_i`, `rdata2_i` in 32: combinational read data. The register file is write-through.
- `ex_wreg_i` in 1, `ex_wd_i` in 5, `ex_wdata_i` in 32: EX-stage result bus.
- `mem_wreg_i` in 1, `mem_wd_i` in 5, `mem_wdata_i` in 32: MEM-stage result bus.
- `valid_o` out 1: registered; EX operation valid.
- `aluop_o` out 8, `alusel_o` out 3: registered.
- `reg1_o`, `reg2_o` out 32: registered operands.
- `wd_o` out 5, `wreg_o` out 1: registered destination and write enable.
- `stallreq_o` out 1: combinational hazard stall request to the pipeline controller.

## Operation
Encodings:
- aluop: OR 8'b00100101, AND 8'b00100100, XOR 8'b00100110, NOR 8'b00100111, SLL 8'b01111100, SRL 8'b00000010, SRA 8'b00000011, NOP 8'b0.
- alusel: NOP 3'b000, LOGIC 3'b001, SHIFT 3'b010.

Decode classes:
- SPECIAL (op 000000), R-type logic, funct 100100/100101/100110/100111 = AND/OR/XOR/NOR:
  - reg1 = rs, reg2 = rt, wd = rd.
  - Both reads enabled; alusel LOGIC.
- SPECIAL shifts, funct 000000/000010/000011 = SLL/SRL/SRA:
  - re1 = 0, reg1 = zero-extended inst[10:6] (shamt).
  - reg2 = rt, wd = rd; alusel SHIFT.
- Logic immediates, op 001100/001101/001110 = ANDI/ORI/XORI:
  - reg1 = rs, reg2 = zero-extended imm16, wd = rt.
  - re2 = 0; alusel LOGIC.
- LUI, op 001111: aluop OR, reg1 = 0, reg2 = {imm16, 16'h0}, wd = rt, no reads.
- Any other encoding: NOP, `wreg` = 0, `valid` = 1 (treated as a bubble-equivalent op).

Write enable and operand rules:
- `wreg` = 1 for every recognised op, except when wd == 0, which forces `wreg` = 0.
- Operand selection, per port, highest priority first:
  1. Address 0 → 32'h0.
  2. EX match (`ex_wreg_i` and `ex_wd_i` == addr) → `ex_wdata_i`.
  3. MEM match → `mem_wdata_i`.
  4. Otherwise `rdata*_i`.
- A disabled read port contributes its immediate/shamt value and never matches a hazard.

ID/EX register update at each edge, highest priority first:
1. `rst`: all outputs 0, equivalent to a NOP.
2. `flush_i`: load NOP, `valid_o` = 0.
3. `stall_i`: hold all outputs.
4. Accepted instruction: load the decoded operation, `valid_o` = 1.
5. Otherwise: load NOP, `valid_o` = 0.

Handshake:
- `inst_ready_o` = !rst && !stall_i && !flush_i && !hazard.
- Fetch must hold `inst_i` while ready is low.

## Timing
- Decode, read and forwarding are combinational in cycle N. EX sees the operation in cycle N+1. Latency is one cycle, throughput one per cycle.
- `stallreq_o` and `inst_ready_o` are combinational from the current `inst_i` and the forwarding buses.
- Simultaneous `flush_i` and `stall_i`: flush wins. No instruction is accepted that cycle.
- A flush or reset mid-hazard drops the stalled instruction. Fetch re-presents it per its own rules.

## Configuration
`ID_FORWARD_EN`:
- Defined: forwarding is as above; hazard = 0 and `stallreq_o` = 0.
- Undefined:
  - The EX and MEM buses are compared only, never selected.
  - hazard = an enabled port with a nonzero address that matches EX or MEM (both with wreg set).
  - `stallreq_o` = hazard; the ID/EX register loads bubbles until the match clears. That takes at most 2 cycles with no downstream stall.

## Test plan
- ORI $1,$0,0x1100 (0x34011100): next edge gives aluop 0x25, alusel 1, reg1 0, reg2 0x00001100, wd 1, wreg 1, valid 1.
- OR $3,$1,$2 with EX bus writing $1 = 0x0000FF00 and the regfile holding $1 = 0, $2 = 0x00F0: reg1 = 0x0000FF00 (forwarded). Without `ID_FORWARD_EN`: `stallreq_o` = 1, one bubble (`valid_o` = 0), then accepted.
- EX and MEM both target $2, with 0xAAAA and 0xBBBB: reg2 = 0xAAAA.
- LUI $5,0x1234 then SLL $6,$5,4: outputs reg2 0x12340000, then reg1 4, aluop 0x7C, alusel 2.
- Hold `stall_i` for 3 cycles mid-stream: outputs frozen and `inst_ready_o` = 0. Assert `flush_i` together with `stall_i`: next edge `valid_o` = 0, aluop 0.
- OR $0,$1,$2 gives `wreg_o` = 0. Undefined opcode 0xFC000000 gives NOP. Asserting `rst` mid-stream zeroes all outputs at the next edge.

Source files
------------

// File: rtl/id_stage.sv
// MIPS32 decode stage with ID/EX pipeline register (logic, shift, logic-immediate, LUI).
// Define ID_FORWARD_EN to forward EX/MEM results; otherwise operand hazards stall.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_i,
    output logic        inst_ready_o,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        re1_o,
    output logic        re2_o,
    output logic [4:0]  raddr1_o,
    output logic [4:0]  raddr2_o,
    input  logic [31:0] rdata1_i,
    input  logic [31:0] rdata2_i,
    input  logic        ex_wreg_i,
    input  logic [4:0]  ex_wd_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        mem_wreg_i,
    input  logic [4:0]  mem_wd_i,
    input  logic [31:0] mem_wdata_i,
    output logic        valid_o,
    output logic [7:0]  aluop_o,
    output logic [2:0]  alusel_o,
    output logic [31:0] reg1_o,
    output logic [31:0] reg2_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic        stallreq_o
);

    localparam logic [7:0] ALU_OR  = 8'b00100101;
    localparam logic [7:0] ALU_AND = 8'b00100100;
    localparam logic [7:0] ALU_XOR = 8'b00100110;
    localparam logic [7:0] ALU_SLL = 8'b01111100;
    localparam logic [7:0] ALU_SRL = 8'b00000010;
    localparam logic [7:0] ALU_SRA = 8'b00000011;
    localparam logic [7:0] ALU_NOP = 8'b00000000;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    typedef struct packed {
        logic        valid;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
    } idex_t;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;

    assign op    = inst_i[31:26];
    assign rs    = inst_i[25:21];
    assign rt    = inst_i[20:16];
    assign rd    = inst_i[15:11];
    assign shamt = inst_i[10:6];
    assign funct = inst_i[5:0];
    assign imm   = inst_i[15:0];

    logic        re1, re2, known;
    logic [31:0] imm1, imm2;
    logic [7:0]  dec_aluop;
    logic [2:0]  dec_alusel;
    logic [4:0]  dec_wd;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        re1        = 1'b0;
        re2        = 1'b0;
        known      = 1'b0;
        imm1       = 32'h0;
        imm2       = 32'h0;
        dec_aluop  = ALU_NOP;
        dec_alusel = SEL_NOP;
        dec_wd     = 5'd0;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    6'b100100, 6'b100101, 6'b100110, 6'b100111: begin
                        re1 = 1'b1; re2 = 1'b1; known = 1'b1;
                        dec_aluop = {2'b00, funct}; dec_alusel = SEL_LOGIC; dec_wd = rd;
                    end
                    6'b000000, 6'b000010, 6'b000011: begin
                        re2 = 1'b1; known = 1'b1;
                        imm1 = {27'h0, shamt};
                        dec_aluop = (funct == 6'b000000) ? ALU_SLL :
                                    (funct == 6'b000010) ? ALU_SRL : ALU_SRA;
                        dec_alusel = SEL_SHIFT; dec_wd = rd;
                    end
                    default: ;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                re1 = 1'b1; known = 1'b1;
                imm2 = {16'h0, imm};
                dec_aluop = (op == OP_ANDI) ? ALU_AND : (op == OP_ORI) ? ALU_OR : ALU_XOR;
                dec_alusel = SEL_LOGIC; dec_wd = rt;
            end
            OP_LUI: begin
                known = 1'b1;
                imm2 = {imm, 16'h0};
                dec_aluop = ALU_OR; dec_alusel = SEL_LOGIC; dec_wd = rt;
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] select_operand(
        input logic        re,
        input logic [4:0]  addr,
        input logic [31:0] rdata,
        input logic [31:0] imm_val,
        input logic        ex_wreg,
        input logic [4:0]  ex_wd,
        input logic [31:0] ex_wdata,
        input logic        mem_wreg,
        input logic [4:0]  mem_wd,
        input logic [31:0] mem_wdata
    );
        if (!re)                              return imm_val;
        if (addr == 5'd0)                     return 32'h0;
        if (ex_wreg && ex_wd == addr)         return ex_wdata;
        if (mem_wreg && mem_wd == addr)       return mem_wdata;
        return rdata;
    endfunction

    logic        hazard;
    logic [31:0] op1, op2;

`ifdef ID_FORWARD_EN
    assign op1    = select_operand(re1, rs, rdata1_i, imm1, ex_wreg_i, ex_wd_i, ex_wdata_i,
                                   mem_wreg_i, mem_wd_i, mem_wdata_i);
    assign op2    = select_operand(re2, rt, rdata2_i, imm2, ex_wreg_i, ex_wd_i, ex_wdata_i,
                                   mem_wreg_i, mem_wd_i, mem_wdata_i);
    assign hazard = 1'b0;
`else
    logic hit1, hit2;
    logic unused_fwd_data;

    // Buses are only compared here; forwarding disabled means the result must reach the regfile first.
    assign op1  = select_operand(re1, rs, rdata1_i, imm1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    assign op2  = select_operand(re2, rt, rdata2_i, imm2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    assign hit1 = re1 && (rs != 5'd0) &&
                  ((ex_wreg_i && ex_wd_i == rs) || (mem_wreg_i && mem_wd_i == rs));
    assign hit2 = re2 && (rt != 5'd0) &&
                  ((ex_wreg_i && ex_wd_i == rt) || (mem_wreg_i && mem_wd_i == rt));
    assign hazard = inst_valid_i && (hit1 || hit2);
    assign unused_fwd_data = ^{ex_wdata_i, mem_wdata_i};
`endif

    assign re1_o        = re1;
    assign re2_o        = re2;
    assign raddr1_o     = rs;
    assign raddr2_o     = rt;
    assign stallreq_o   = hazard;
    assign inst_ready_o = !rst && !stall_i && !flush_i && !hazard;

    logic  accept;
    idex_t dec, idex;

    assign accept = inst_valid_i && inst_ready_o;

    always_comb begin
        dec        = '0;
        dec.valid  = 1'b1;
        dec.aluop  = dec_aluop;
        dec.alusel = dec_alusel;
        dec.reg1   = op1;
        dec.reg2   = op2;
        dec.wd     = dec_wd;
        dec.wreg   = known && (dec_wd != 5'd0);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst || flush_i) idex <= '0;
        else if (stall_i)   idex <= idex;
        else if (accept)    idex <= dec;
        else                idex <= '0;
    end

    assign valid_o  = idex.valid;
    assign aluop_o  = idex.aluop;
    assign alusel_o = idex.alusel;
    assign reg1_o   = idex.reg1;
    assign reg2_o   = idex.reg2;
    assign wd_o     = idex.wd;
    assign wreg_o   = idex.wreg;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; follows ID_FORWARD_EN when defined.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst, inst_valid_i, flush_i, stall_i;
    logic [31:0] inst_i;
    logic        inst_ready_o, re1_o, re2_o;
    logic [4:0]  raddr1_o, raddr2_o;
    logic [31:0] rdata1_i, rdata2_i;
    logic        ex_wreg_i, mem_wreg_i;
    logic [4:0]  ex_wd_i, mem_wd_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;
    logic        valid_o, wreg_o, stallreq_o;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;
    logic [31:0] reg1_o, reg2_o;
    logic [4:0]  wd_o;

    logic [31:0] rf [32];
    int n_total = 0;
    int n_bad   = 0;

    assign rdata1_i = rf[raddr1_o];
    assign rdata2_i = rf[raddr2_o];

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .inst_i(inst_i),
        .inst_ready_o(inst_ready_o), .flush_i(flush_i), .stall_i(stall_i),
        .re1_o(re1_o), .re2_o(re2_o), .raddr1_o(raddr1_o), .raddr2_o(raddr2_o),
        .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .valid_o(valid_o), .aluop_o(aluop_o), .alusel_o(alusel_o),
        .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .stallreq_o(stallreq_o)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Packed view of every registered output: {valid, aluop, alusel, reg1, reg2, wd, wreg}.
    function automatic logic [95:0] outs();
        return {14'h0, valid_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o};
    endfunction

    function automatic logic [95:0] pack(input logic v, input logic [7:0] a, input logic [2:0] s,
                                         input logic [31:0] r1, input logic [31:0] r2,
                                         input logic [4:0] w, input logic we);
        return {14'h0, v, a, s, r1, r2, w, we};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[2] = 32'h000000F0;
        rst = 1'b1; inst_valid_i = 1'b0; inst_i = 32'h0; flush_i = 1'b0; stall_i = 1'b0;
        ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_wdata_i = 32'h0;
        mem_wreg_i = 1'b0; mem_wd_i = 5'd0; mem_wdata_i = 32'h0;

        tick(); tick();
        check("reset_outs", outs(), '0);
        check("reset_ready", inst_ready_o, 1'b0);

        // ORI $1,$0,0x1100 with EX bus targeting $0, which must not count as a hazard
        rst = 1'b0; inst_valid_i = 1'b1; inst_i = 32'h34011100;
        ex_wreg_i = 1'b1; ex_wd_i = 5'd0; ex_wdata_i = 32'hDEAD0000;
        settle();
        check("ori_stallreq", stallreq_o, 1'b0);
        check("ori_ready", inst_ready_o, 1'b1);
        tick();
        check("ori_outs", outs(), pack(1'b1, 8'h25, 3'd1, 32'h0, 32'h00001100, 5'd1, 1'b1));

        // OR $3,$1,$2 with EX writing $1
        inst_i = 32'h00221825;
        ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'h0000FF00;
        settle();
`ifdef ID_FORWARD_EN
        check("or_fwd_stallreq", stallreq_o, 1'b0);
        tick();
        check("or_fwd_outs", outs(), pack(1'b1, 8'h25, 3'd1, 32'h0000FF00, 32'hF0, 5'd3, 1'b1));
        rf[1] = 32'h0000FF00; ex_wreg_i = 1'b0;
`else
        check("or_haz_stallreq", stallreq_o, 1'b1);
        check("or_haz_ready", inst_ready_o, 1'b0);
        tick();
        check("or_bubble_valid", valid_o, 1'b0);
        rf[1] = 32'h0000FF00; ex_wreg_i = 1'b0;
        settle();
        check("or_clear_stallreq", stallreq_o, 1'b0);
        tick();
        check("or_outs", outs(), pack(1'b1, 8'h25, 3'd1, 32'h0000FF00, 32'hF0, 5'd3, 1'b1));
`endif

        // EX and MEM both target $2: EX has priority
        ex_wreg_i = 1'b1; ex_wd_i = 5'd2; ex_wdata_i = 32'h0000AAAA;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd2; mem_wdata_i = 32'h0000BBBB;
        settle();
`ifdef ID_FORWARD_EN
        tick();
        check("exmem_prio_reg2", reg2_o, 32'h0000AAAA);
        rf[2] = 32'h0000AAAA; ex_wreg_i = 1'b0; mem_wreg_i = 1'b0;
`else
        check("exmem_stallreq", stallreq_o, 1'b1);
        tick();
        ex_wreg_i = 1'b0;
        settle();
        check("mem_only_stallreq", stallreq_o, 1'b1);
        tick();
        check("mem_bubble_valid", valid_o, 1'b0);
        rf[2] = 32'h0000AAAA; mem_wreg_i = 1'b0;
        tick();
        check("exmem_reg2", reg2_o, 32'h0000AAAA);
`endif

        // ORI $4,$0,5: disabled read port 2 addresses $4, EX writing $4 must not match
        inst_i = 32'h34040005;
        ex_wreg_i = 1'b1; ex_wd_i = 5'd4; ex_wdata_i = 32'h12345678;
        settle();
        check("ori_noport_stallreq", stallreq_o, 1'b0);
        tick();
        check("ori_noport_outs", outs(), pack(1'b1, 8'h25, 3'd1, 32'h0, 32'h5, 5'd4, 1'b1));
        ex_wreg_i = 1'b0;

        // LUI $5,0x1234 then SLL $6,$5,4
        inst_i = 32'h3C051234;
        settle();
        check("lui_reads", {re1_o, re2_o}, 2'b00);
        tick();
        check("lui_outs", outs(), pack(1'b1, 8'h25, 3'd1, 32'h0, 32'h12340000, 5'd5, 1'b1));
        rf[5] = 32'h12340000;
        inst_i = 32'h00053100;
        settle();
        check("sll_re1", re1_o, 1'b0);
        tick();
        check("sll_outs", outs(), pack(1'b1, 8'h7C, 3'd2, 32'h4, 32'h12340000, 5'd6, 1'b1));

        // XOR $7,$1,$2 presented while stall is held for 3 cycles, then flush+stall
        inst_i = 32'h00223826;
        stall_i = 1'b1;
        settle();
        check("stall_ready", inst_ready_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", outs(), pack(1'b1, 8'h7C, 3'd2, 32'h4, 32'h12340000, 5'd6, 1'b1));
        end
        flush_i = 1'b1;
        settle();
        check("flush_ready", inst_ready_o, 1'b0);
        tick();
        check("flush_outs", outs(), '0);
        flush_i = 1'b0; stall_i = 1'b0;
        tick();
        check("xor_outs", outs(), pack(1'b1, 8'h26, 3'd1, 32'h0000FF00, 32'h0000AAAA, 5'd7, 1'b1));

        // SRA $8,$2,31 and ANDI $9,$1,0xFFFF
        inst_i = 32'h000247C3;
        tick();
        check("sra_outs", outs(), pack(1'b1, 8'h03, 3'd2, 32'h1F, 32'h0000AAAA, 5'd8, 1'b1));
        inst_i = 32'h3029FFFF;
        tick();
        check("andi_outs", outs(), pack(1'b1, 8'h24, 3'd1, 32'h0000FF00, 32'h0000FFFF, 5'd9, 1'b1));

        // OR $0,$1,$2 never writes; undefined opcode decodes to a valid NOP
        inst_i = 32'h00220025;
        tick();
        check("or_r0_outs", outs(), pack(1'b1, 8'h25, 3'd1, 32'h0000FF00, 32'h0000AAAA, 5'd0, 1'b0));
        inst_i = 32'hFC000000;
        settle();
        check("undef_reads", {re1_o, re2_o}, 2'b00);
        tick();
        check("undef_outs", outs(), pack(1'b1, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0));

        // No valid instruction loads a bubble
        inst_valid_i = 1'b0;
        tick();
        check("idle_valid", valid_o, 1'b0);

        // Reset mid-stream after a real op
        inst_valid_i = 1'b1; inst_i = 32'h34011100;
        tick();
        check("pre_rst_valid", valid_o, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_rst_outs", outs(), '0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
